// File: rtl/rs_dec_chan_sched.sv
// Two-channel round-robin scheduler for a shared variable-check RS decoder.
// Optional per-channel statistics counters are enabled by defining RS_SCHED_STATS_EN.
module rs_dec_chan_sched #(
  parameter int M         = 4,
  parameter int WIDE      = 3,
  parameter int TAG_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [1:0]      ch_val_i,
  input  logic [M-1:0]    ch_sym0_i,
  input  logic [M-1:0]    ch_sym1_i,
  input  logic [M-1:0]    ch_numn0_i,
  input  logic [M-1:0]    ch_numn1_i,
  input  logic [WIDE-1:0] ch_numchk0_i,
  input  logic [WIDE-1:0] ch_numchk1_i,
  output logic [1:0]      ch_rdy_o,
  output logic [1:0]      ch_cfg_err_o,
  input  logic            dec_ena_i,
  output logic            dec_val_o,
  output logic            dec_sop_o,
  output logic            dec_eop_o,
  output logic [M-1:0]    dec_rsin_o,
  output logic [M-1:0]    dec_numn_o,
  output logic [WIDE-1:0] dec_numchk_o,
  input  logic            dec_src_val_i,
  input  logic            dec_src_sop_i,
  input  logic            dec_src_eop_i,
  input  logic            dec_decfail_i,
  input  logic [M-1:0]    dec_rsout_i,
  output logic            dec_src_ena_o,
  output logic [1:0]      out_val_o,
  output logic            out_sop_o,
  output logic            out_eop_o,
  output logic            out_decfail_o,
  output logic [M-1:0]    out_sym_o,
  input  logic [1:0]      out_rdy_i
`ifdef RS_SCHED_STATS_EN
  ,
  output logic [15:0]     stat_cw0_o,
  output logic [15:0]     stat_cw1_o,
  output logic [15:0]     stat_fail0_o,
  output logic [15:0]     stat_fail1_o
`endif
);

  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = ((M > WIDE) ? M : WIDE) + 1;
  localparam logic [AW:0] FULL_OCC = (AW+1)'(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE, GRANT, STREAM, DRAIN_WAIT} state_e;

  state_e          state_q, state_d;
  logic            rr_q, rr_d;
  logic            owner_q, owner_d;
  logic [M-1:0]    numn_q, numn_d;
  logic [WIDE-1:0] numchk_q, numchk_d;
  logic [M-1:0]    cnt_q, cnt_d;
  logic [1:0]      cfg_err_q, cfg_err_d;

  logic [TAG_DEPTH-1:0] tag_q;
  logic [AW-1:0]        wr_q, rd_q;
  logic [AW:0]          occ_q;

  logic [1:0]      req;
  logic            win, win_legal, full, empty, push, pop, head;
  logic            streaming, own_val, xfer, last;

  function automatic logic cfg_legal(input logic [M-1:0] n, input logic [WIDE-1:0] k);
    return (n != '0) && (CW'(n) > CW'(k));
  endfunction

  // A channel that just got a cfg_err pulse sits out one arbitration round
  assign req       = ch_val_i & ~cfg_err_q;
  assign win       = (req == 2'b11) ? rr_q : req[1];
  assign win_legal = win ? cfg_legal(ch_numn1_i, ch_numchk1_i)
                         : cfg_legal(ch_numn0_i, ch_numchk0_i);
  assign full      = (occ_q == FULL_OCC);
  assign empty     = (occ_q == '0);

  assign streaming = (state_q == STREAM);
  assign own_val   = owner_q ? ch_val_i[1] : ch_val_i[0];
  assign xfer      = streaming & own_val & dec_ena_i;
  assign last      = (cnt_q == (numn_q - M'(1)));

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    numn_d    = numn_q;
    numchk_d  = numchk_q;
    cnt_d     = cnt_q;
    cfg_err_d = 2'b00;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          if (!win_legal) begin
            cfg_err_d[win] = 1'b1;
          end else begin
            owner_d = win;
            state_d = full ? DRAIN_WAIT : GRANT;
          end
        end
      end
      DRAIN_WAIT: begin
        if (!full) state_d = GRANT;
      end
      GRANT: begin
        numn_d   = owner_q ? ch_numn1_i : ch_numn0_i;
        numchk_d = owner_q ? ch_numchk1_i : ch_numchk0_i;
        cnt_d    = '0;
        rr_d     = ~owner_q;
        push     = 1'b1;
        state_d  = STREAM;
      end
      STREAM: begin
        if (xfer) begin
          cnt_d = cnt_q + M'(1);
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      owner_q   <= 1'b0;
      numn_q    <= '0;
      numchk_q  <= '0;
      cnt_q     <= '0;
      cfg_err_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      numn_q    <= numn_d;
      numchk_q  <= numchk_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign ch_rdy_o     = streaming ? (owner_q ? {dec_ena_i, 1'b0} : {1'b0, dec_ena_i}) : 2'b00;
  assign ch_cfg_err_o = cfg_err_q;
  assign dec_val_o    = xfer;
  assign dec_sop_o    = xfer & (cnt_q == '0);
  assign dec_eop_o    = xfer & last;
  assign dec_rsin_o   = streaming ? (owner_q ? ch_sym1_i : ch_sym0_i) : '0;
  assign dec_numn_o   = numn_q;
  assign dec_numchk_o = numchk_q;

  // Tag FIFO: owner of each codeword inside the decoder, popped on output eop
  assign head          = tag_q[rd_q];
  assign dec_src_ena_o = ~empty & out_rdy_i[head];
  assign out_val_o     = (~empty & dec_src_val_i) ? (head ? 2'b10 : 2'b01) : 2'b00;
  assign pop           = dec_src_val_i & dec_src_ena_o & dec_src_eop_i;
  assign out_sym_o     = dec_rsout_i;
  assign out_sop_o     = dec_src_sop_i;
  assign out_eop_o     = dec_src_eop_i;
  assign out_decfail_o = dec_decfail_i;

  always_ff @(posedge clk_i) begin
    if (push) tag_q[wr_q] <= owner_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      occ_q <= occ_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

`ifdef RS_SCHED_STATS_EN
  logic [15:0] cw0_q, cw1_q, fail0_q, fail1_q;
  logic        fail_evt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign fail_evt = pop & dec_decfail_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cw0_q   <= '0;
      cw1_q   <= '0;
      fail0_q <= '0;
      fail1_q <= '0;
    end else begin
      if (push && !owner_q) cw0_q <= sat_inc(cw0_q);
      if (push &&  owner_q) cw1_q <= sat_inc(cw1_q);
      if (fail_evt && !head) fail0_q <= sat_inc(fail0_q);
      if (fail_evt &&  head) fail1_q <= sat_inc(fail1_q);
    end
  end

  assign stat_cw0_o   = cw0_q;
  assign stat_cw1_o   = cw1_q;
  assign stat_fail0_o = fail0_q;
  assign stat_fail1_o = fail1_q;
`endif

endmodule
